cpu_dma: RTL and testbench

CPU_DMA -- requirements
Module: cpu_dma

---
 rtl/cpu_dma.sv | 126 ++++++++++++
 tb/tb_cpu_dma.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_dma.sv
// cpu_dma: multi-channel byte-copy DMA that stalls the CPU while it owns the bus.
// Define CPU_DMA_ALIGN_EN to insert one idle ALIGN bus step before the first read.
module cpu_dma #(
    parameter int CHANNELS = 2,
    parameter int LEN_W    = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [CHANNELS-1:0]       req,
    input  logic [16*CHANNELS-1:0]    src,
    input  logic [16*CHANNELS-1:0]    dst,
    input  logic [LEN_W*CHANNELS-1:0] len,
    input  logic [CHANNELS-1:0]       dst_inc,
    output logic                      halt,
    output logic [CHANNELS-1:0]       done,
    output logic [15:0]               A,
    input  logic [7:0]                I,
    output logic [7:0]                D,
    output logic                      R,
    output logic                      W
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
`ifdef CPU_DMA_ALIGN_EN
    typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;
    localparam state_t FIRST = ALIGN;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam state_t FIRST = READ;
`endif
    state_t state_q, state_d;
    logic [CHANNELS-1:0] pend_q, pend_d, done_q, done_d, sel_oh;
    logic [CH_W-1:0] ch_q, ch_d, sel;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc, sel_len;
    logic inc_q, inc_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            done_q <= '0;
            ch_q   <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            inc_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            done_q <= done_d;
            ch_q   <= ch_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            inc_q  <= inc_d;
            data_q <= data_d;
        end
    end

    // Lowest-index pending channel wins arbitration.
    always_comb begin
        sel = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (pend_q[k]) sel = CH_W'(k);
        sel_oh  = CHANNELS'(1) << sel;
        sel_len = len[sel*LEN_W +: LEN_W];
        cnt_inc = cnt_q + LEN_W'(1);
        state_d = state_q;
        pend_d  = pend_q | req;
        done_d  = '0;
        ch_d    = ch_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        inc_d   = inc_q;
        data_d  = data_q;
        if (ce) begin
            case (state_q)
                IDLE: if (|pend_q) begin
                    pend_d = (pend_q & ~sel_oh) | req;
                    ch_d   = sel;
                    src_d  = src[16*sel +: 16];
                    dst_d  = dst[16*sel +: 16];
                    len_d  = sel_len;
                    inc_d  = dst_inc[sel];
                    cnt_d  = '0;
                    if (sel_len == '0) done_d = sel_oh;
                    else state_d = FIRST;
                end
`ifdef CPU_DMA_ALIGN_EN
                ALIGN: state_d = READ;
`endif
                READ: begin
                    data_d  = I;
                    state_d = WRITE;
                end
                WRITE: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = IDLE;
                        done_d  = CHANNELS'(1) << ch_q;
                    end else state_d = READ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        R    = state_q == READ;
        W    = state_q == WRITE;
        A    = R ? src_q + 16'(cnt_q) : W ? (inc_q ? dst_q + 16'(cnt_q) : dst_q) : '0;
        D    = W ? data_q : '0;
        halt = state_q != IDLE || |pend_q;
        done = done_q;
    end
endmodule

// File: tb/tb_cpu_dma.sv
// tb_cpu_dma: directed bench for cpu_dma (default build) with a simple read-data model.
module tb_cpu_dma;
    localparam int CH = 2;
    localparam int LW = 9;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic [CH-1:0] req = '0;
    logic [CH-1:0] dst_inc = '0;
    logic [16*CH-1:0] src = '0;
    logic [16*CH-1:0] dst = '0;
    logic [LW*CH-1:0] len = '0;
    logic halt, R, W;
    logic [CH-1:0] done;
    logic [15:0] A;
    logic [7:0] I, D;
    int n_cmp = 0;
    int n_bad = 0;

    always #20 clock = ~clock;
    // Memory model: each source byte is its low address bits XOR A5.
    assign I = A[7:0] ^ 8'hA5;

    cpu_dma #(.CHANNELS(CH), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset), .ce(ce), .req(req), .src(src), .dst(dst),
        .len(len), .dst_inc(dst_inc), .halt(halt), .done(done), .A(A), .I(I),
        .D(D), .R(R), .W(W)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic cfg(input int ch, input logic [15:0] s, input logic [15:0] d, input logic inc, input int n);
        src[ch*16 +: 16] = s;
        dst[ch*16 +: 16] = d;
        dst_inc[ch] = inc;
        len[ch*LW +: LW] = LW'(n);
    endtask

    // Pulse req for one clock, then let the following edge accept; ends just after acceptance.
    task automatic start(input logic [CH-1:0] r);
        req = r;
        step();
        req = '0;
        chk("pending halt", 32'(halt), 1);
        step();
    endtask

    task automatic bytes(input string t, input logic [15:0] s, input logic [15:0] d, input logic inc,
                         input int first, input int n, input logic tog);
        logic [15:0] ra, wa;
        for (int b = first; b < first + n; b++) begin
            ra = s + 16'(b);
            wa = inc ? d + 16'(b) : d;
            for (int ph = 0; ph < 2; ph++) begin
                for (int rep = 0; rep < (tog ? 2 : 1); rep++) begin
                    if (tog) ce = (rep == 1);
                    chk($sformatf("%s R b%0d", t, b), 32'(R), 32'(ph == 0));
                    chk($sformatf("%s W b%0d", t, b), 32'(W), 32'(ph == 1));
                    chk($sformatf("%s A b%0d", t, b), 32'(A), 32'(ph == 1 ? wa : ra));
                    if (ph == 1) chk($sformatf("%s D b%0d", t, b), 32'(D), 32'(ra[7:0] ^ 8'hA5));
                    chk($sformatf("%s halt b%0d", t, b), 32'(halt), 1);
                    chk($sformatf("%s done b%0d", t, b), 32'(done), 0);
                    step();
                end
            end
        end
        ce = 1'b1;
    endtask

    task automatic fin(input string t, input int ch, input logic exp_halt);
        chk({t, " done"}, 32'(done), 32'(1 << ch));
        chk({t, " idle R"}, 32'(R), 0);
        chk({t, " idle W"}, 32'(W), 0);
        chk({t, " idle A"}, 32'(A), 0);
        chk({t, " idle D"}, 32'(D), 0);
        chk({t, " halt"}, 32'(halt), 32'(exp_halt));
        step();
        chk({t, " done clr"}, 32'(done), 32'(exp_halt ? 0 : 0));
    endtask

    initial begin
        step();
        step();
        chk("rst A", 32'(A), 0);
        chk("rst RW", {30'd0, R, W}, 0);
        chk("rst D", 32'(D), 0);
        chk("rst done", 32'(done), 0);
        chk("rst halt", 32'(halt), 0);
        reset = 1'b0;
        step();
        // len=0: done one clock after acceptance, no strobes
        cfg(0, 16'h1234, 16'h5678, 1'b1, 0);
        start(2'b01);
        fin("s5", 0, 1'b0);
        chk("s5 R", 32'(R), 0);
        chk("s5 W", 32'(W), 0);
        // 256 bytes into a fixed port
        cfg(0, 16'h0200, 16'h2004, 1'b0, 256);
        start(2'b01);
        bytes("s1", 16'h0200, 16'h2004, 1'b0, 0, 256, 1'b0);
        fin("s1", 0, 1'b0);
        // simultaneous requests: ch0 then ch1, halt stays high between them
        cfg(0, 16'h0400, 16'h0500, 1'b1, 2);
        cfg(1, 16'h0600, 16'h0700, 1'b1, 2);
        start(2'b11);
        bytes("s2a", 16'h0400, 16'h0500, 1'b1, 0, 2, 1'b0);
        chk("s2 done0", 32'(done), 1);
        chk("s2 halt gap", 32'(halt), 1);
        step();
        bytes("s2b", 16'h0600, 16'h0700, 1'b1, 0, 2, 1'b0);
        fin("s2b", 1, 1'b0);
        // ce toggling: every strobe two clocks
        cfg(0, 16'h1000, 16'h2004, 1'b0, 3);
        start(2'b01);
        bytes("s3", 16'h1000, 16'h2004, 1'b0, 0, 3, 1'b1);
        fin("s3", 0, 1'b0);
        // address wrap; inputs changed after acceptance must not matter
        cfg(1, 16'hFFFF, 16'hFFFE, 1'b1, 3);
        start(2'b10);
        cfg(1, 16'h0000, 16'h0000, 1'b0, 7);
        bytes("s4", 16'hFFFF, 16'hFFFE, 1'b1, 0, 3, 1'b0);
        fin("s4", 1, 1'b0);
        // reset in the WRITE of byte 5 aborts; a req during reset is dropped
        cfg(0, 16'h0300, 16'h4000, 1'b1, 8);
        start(2'b01);
        bytes("s6", 16'h0300, 16'h4000, 1'b1, 0, 4, 1'b0);
        chk("s6 read5", 32'(A), 32'h0304);
        step();
        chk("s6 write5", 32'(W), 1);
        reset = 1'b1;
        req = 2'b01;
        step();
        chk("s6 A", 32'(A), 0);
        chk("s6 RW", {30'd0, R, W}, 0);
        chk("s6 D", 32'(D), 0);
        chk("s6 done", 32'(done), 0);
        chk("s6 halt", 32'(halt), 0);
        reset = 1'b0;
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s6 quiet", {28'd0, halt, done, R}, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
